// File: rtl/lynxTypes.sv
// lynxTypes
//   Shared constants for the stream datapath blocks.
//   AXI_DATA_BITS : default AXI4-Stream payload width used across the codebase.
package lynxTypes;

  localparam int AXI_DATA_BITS = 64;

endpackage : lynxTypes

// File: rtl/axis_credit_fifo.sv
// axis_credit_fifo
//   Synchronous show-ahead FIFO built as a shift register: entry 0 is always
//   the head, so rd_data comes straight from a register.
//   Parameters: DEPTH (entries), DATA_BITS (payload width)
//   Ports:
//     aclk     in   clock
//     aresetn  in   synchronous active-low reset (empties FIFO, clears data)
//     wr_en    in   push wr_data (ignored when full)
//     wr_data  in   payload to push
//     rd_en    in   pop head (ignored when empty)
//     rd_data  out  current head, zero when empty
//     full     out  DEPTH entries held
//     empty    out  no entries held
module axis_credit_fifo #(
  parameter int DEPTH     = 4,
  parameter int DATA_BITS = 64
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 full,
  output logic                 empty
);

  localparam int                CNT_BITS = $clog2(DEPTH + 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1'b1);
  localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(DEPTH);

  logic [DATA_BITS-1:0] mem_r     [DEPTH];
  logic [DATA_BITS-1:0] mem_nxt_s [DEPTH];
  logic [CNT_BITS-1:0]  cnt_r;
  logic [CNT_BITS-1:0]  cnt_nxt_s;
  logic [CNT_BITS-1:0]  wpos_s;
  logic                 full_r;
  logic                 empty_r;
  logic                 wr_go_s;
  logic                 rd_go_s;

  // Next-state: shift on pop, then drop the write into the first free slot.
  always_comb begin
    wr_go_s   = wr_en & ~full_r;
    rd_go_s   = rd_en & ~empty_r;
    cnt_nxt_s = cnt_r;
    if (wr_go_s && !rd_go_s) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else if (!wr_go_s && rd_go_s) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
    // A pop frees the slot below the current tail, so the write lands one lower.
    wpos_s = rd_go_s ? (cnt_r - CNT_ONE) : cnt_r;
    for (int i = 0; i < DEPTH - 1; i++) begin
      mem_nxt_s[i] = rd_go_s ? mem_r[i+1] : mem_r[i];
    end
    mem_nxt_s[DEPTH-1] = rd_go_s ? {DATA_BITS{1'b0}} : mem_r[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      mem_nxt_s[i] = (wr_go_s && (CNT_BITS'(i) == wpos_s)) ? wr_data : mem_nxt_s[i];
    end
  end

  // Storage, occupancy and registered flags.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_BITS{1'b0}};
      end
      cnt_r   <= CNT_ZERO;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= mem_nxt_s[i];
      end
      cnt_r   <= cnt_nxt_s;
      full_r  <= (cnt_nxt_s == CNT_FULL);
      empty_r <= (cnt_nxt_s == CNT_ZERO);
    end
  end

  assign rd_data = mem_r[0];
  assign full    = full_r;
  assign empty   = empty_r;

  axis_credit_fifo_chk u_chk (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (wr_en),
    .full    (full_r)
  );

endmodule : axis_credit_fifo

// File: rtl/axis_credit_fifo_chk.sv
// axis_credit_fifo_chk
//   Property checker bound inside axis_credit_fifo.
//   Ports:
//     aclk    in  clock
//     aresetn in  synchronous active-low reset
//     wr_en   in  FIFO write request
//     full    in  FIFO full flag
module axis_credit_fifo_chk (
  input logic aclk,
  input logic aresetn,
  input logic wr_en,
  input logic full
);

  // The upstream credit counter must never let a beat reach a full FIFO.
  property p_no_write_when_full;
    @(posedge aclk) disable iff (!aresetn) !(wr_en && full);
  endproperty

  a_no_write_when_full : assert property (p_no_write_when_full);

endmodule : axis_credit_fifo_chk

// File: rtl/axis_reg_pipe_credit_ctrl.sv
// axis_reg_pipe_credit_ctrl
//   AXI4-Stream wrapper around a fixed-latency register pipeline that cannot
//   stall. A credit counter sized to the tail FIFO only admits a beat when the
//   FIFO is certain to have room for it when it leaves the pipeline.
//   Optional build macro: AXIS_PIPE_CTRL_STATS_EN adds saturating counters
//   stat_beats (downstream handshakes) and stat_stall (blocked upstream cycles).
//   Parameters: N_STAGES (>=1), FIFO_DEPTH (>=N_STAGES+2 for full rate), DATA_BITS
//   Ports:
//     aclk / aresetn           clock, synchronous active-low reset
//     s_axis_tvalid/tready/tdata  upstream stream (tready = credit available)
//     m_axis_tvalid/tready/tdata  downstream stream (FIFO head)
//     stat_beats / stat_stall     32-bit counters (macro builds only)
module axis_reg_pipe_credit_ctrl
  import lynxTypes::*;
#(
  parameter int N_STAGES   = 2,
  parameter int FIFO_DEPTH = N_STAGES + 2,
  parameter int DATA_BITS  = AXI_DATA_BITS
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [DATA_BITS-1:0] m_axis_tdata
`ifdef AXIS_PIPE_CTRL_STATS_EN
  ,
  output logic [31:0]          stat_beats,
  output logic [31:0]          stat_stall
`endif
);

  localparam int                   CRED_BITS = $clog2(FIFO_DEPTH + 1);
  localparam logic [CRED_BITS-1:0] CRED_FULL = CRED_BITS'(FIFO_DEPTH);
  localparam logic [CRED_BITS-1:0] CRED_ONE  = CRED_BITS'(1'b1);
  localparam logic [CRED_BITS-1:0] CRED_ZERO = {CRED_BITS{1'b0}};

  logic [CRED_BITS-1:0] credit_cnt_r;
  logic [N_STAGES-1:0]  stg_vld_r;
  logic [DATA_BITS-1:0] stg_dat_r [N_STAGES];
  logic                 accept_s;
  logic                 m_hs_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;

  // Ready depends only on the credit register, never on m_axis_tready.
  assign s_axis_tready = (credit_cnt_r != CRED_ZERO);
  assign accept_s      = s_axis_tvalid & s_axis_tready;
  assign m_axis_tvalid = ~fifo_empty_s;
  assign m_hs_s        = m_axis_tvalid & m_axis_tready;

  // Credit counter: one credit per beat that is accepted but not yet delivered.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      credit_cnt_r <= CRED_FULL;
    end else if (accept_s && !m_hs_s) begin
      credit_cnt_r <= credit_cnt_r - CRED_ONE;
    end else if (!accept_s && m_hs_s) begin
      credit_cnt_r <= credit_cnt_r + CRED_ONE;
    end else begin
      credit_cnt_r <= credit_cnt_r;
    end
  end

  // Free-running pipeline: every stage advances each cycle, no enable.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stg_vld_r <= {N_STAGES{1'b0}};
      for (int i = 0; i < N_STAGES; i++) begin
        stg_dat_r[i] <= {DATA_BITS{1'b0}};
      end
    end else begin
      stg_vld_r[0] <= accept_s;
      stg_dat_r[0] <= s_axis_tdata;
      for (int i = 1; i < N_STAGES; i++) begin
        stg_vld_r[i] <= stg_vld_r[i-1];
        stg_dat_r[i] <= stg_dat_r[i-1];
      end
    end
  end

  axis_credit_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .DATA_BITS (DATA_BITS)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (stg_vld_r[N_STAGES-1]),
    .wr_data (stg_dat_r[N_STAGES-1]),
    .rd_en   (m_hs_s),
    .rd_data (m_axis_tdata),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

`ifdef AXIS_PIPE_CTRL_STATS_EN
  logic [31:0] stat_beats_r;
  logic [31:0] stat_stall_r;

  // Saturating counters for delivered beats and blocked upstream cycles.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stat_beats_r <= 32'd0;
      stat_stall_r <= 32'd0;
    end else begin
      if (m_hs_s && (stat_beats_r != 32'hFFFF_FFFF)) begin
        stat_beats_r <= stat_beats_r + 32'd1;
      end else begin
        stat_beats_r <= stat_beats_r;
      end
      if (s_axis_tvalid && !s_axis_tready && (stat_stall_r != 32'hFFFF_FFFF)) begin
        stat_stall_r <= stat_stall_r + 32'd1;
      end else begin
        stat_stall_r <= stat_stall_r;
      end
    end
  end

  assign stat_beats = stat_beats_r;
  assign stat_stall = stat_stall_r;
`endif

  // The full flag only feeds the FIFO's own checker; keep it observable here.
  logic unused_full_s;
  assign unused_full_s = fifo_full_s;

endmodule : axis_reg_pipe_credit_ctrl

// File: tb/tb_axis_reg_pipe_credit_ctrl.sv
// tb_axis_reg_pipe_credit_ctrl
//   Directed bench for axis_reg_pipe_credit_ctrl (N_STAGES=2, FIFO_DEPTH=4,
//   DATA_BITS=64). A queue model tracks beats accepted but not yet delivered:
//   ready = fewer than FIFO_DEPTH outstanding, a beat is presentable
//   N_STAGES+1 cycles after its accept. Literal checks pin timing per scenario.
//   Build with AXIS_PIPE_CTRL_STATS_EN to also check the statistics counters.
module tb_axis_reg_pipe_credit_ctrl;

  localparam int N_STAGES   = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int DATA_BITS  = 64;

  logic                 aclk = 1'b0;
  logic                 aresetn = 1'b0;
  logic                 s_axis_tvalid = 1'b0;
  logic                 s_axis_tready;
  logic [DATA_BITS-1:0] s_axis_tdata = 64'd0;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready = 1'b0;
  logic [DATA_BITS-1:0] m_axis_tdata;
`ifdef AXIS_PIPE_CTRL_STATS_EN
  logic [31:0]          stat_beats;
  logic [31:0]          stat_stall;
`endif

  always #5 aclk = ~aclk;

  axis_reg_pipe_credit_ctrl #(
    .N_STAGES   (N_STAGES),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_BITS  (DATA_BITS)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata)
`ifdef AXIS_PIPE_CTRL_STATS_EN
    ,
    .stat_beats    (stat_beats),
    .stat_stall    (stat_stall)
`endif
  );

  typedef struct {
    logic [63:0] d;
    int          t;
  } ent_t;

  ent_t        mq[$];
  int          checks = 0;
  int          errors = 0;
  int          gcyc = 0;
  int          base = 0;
  logic [31:0] beats_mdl = 32'd0;
  logic [31:0] stall_mdl = 32'd0;

  // Observation logs, relative to the current scenario start.
  int          acc_cyc[$];
  int          out_cyc[$];
  logic [63:0] out_dat[$];
  logic        rdy_log[$];
  int          vld_cnt = 0;
  logic        snap_acc;
  int          snap_credit;
  logic        snap_tready;
  logic        snap_mvalid;
  logic [63:0] snap_mdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, gcyc - base);
    end
  endtask

  task automatic clr();
    base = gcyc;
    acc_cyc.delete();
    out_cyc.delete();
    out_dat.delete();
    rdy_log.delete();
    vld_cnt = 0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, step.
  task automatic cycle();
    logic exp_tready;
    logic exp_mvalid;
    @(negedge aclk);
    exp_tready = (mq.size() < FIFO_DEPTH);
    exp_mvalid = 1'b0;
    if (mq.size() > 0) exp_mvalid = (mq[0].t <= gcyc);
    chk("s_tready", s_axis_tready, exp_tready);
    chk("m_tvalid", m_axis_tvalid, exp_mvalid);
    if (exp_mvalid) chk("m_tdata", m_axis_tdata, mq[0].d);
`ifdef AXIS_PIPE_CTRL_STATS_EN
    chk("stat_beats", stat_beats, beats_mdl);
    chk("stat_stall", stat_stall, stall_mdl);
`endif
    snap_tready = s_axis_tready;
    snap_mvalid = m_axis_tvalid;
    snap_mdata  = m_axis_tdata;
    snap_credit = int'(dut.credit_cnt_r);
    snap_acc    = s_axis_tvalid && s_axis_tready;
    rdy_log.push_back(s_axis_tready);
    if (m_axis_tvalid) vld_cnt++;
    if (snap_acc) acc_cyc.push_back(gcyc - base);
    if (m_axis_tvalid && m_axis_tready) begin
      out_cyc.push_back(gcyc - base);
      out_dat.push_back(m_axis_tdata);
    end
    if (s_axis_tvalid && !exp_tready && stall_mdl != 32'hFFFF_FFFF) stall_mdl = stall_mdl + 32'd1;
    if (exp_mvalid && m_axis_tready) begin
      void'(mq.pop_front());
      if (beats_mdl != 32'hFFFF_FFFF) beats_mdl = beats_mdl + 32'd1;
    end
    if (s_axis_tvalid && exp_tready) mq.push_back('{s_axis_tdata, gcyc + N_STAGES + 1});
    @(posedge aclk);
    #1;
    gcyc++;
  endtask

  task automatic do_reset(input int n);
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    s_axis_tdata  = 64'd0;
    repeat (n) @(posedge aclk);
    #1;
    aresetn   = 1'b1;
    mq.delete();
    beats_mdl = 32'd0;
    stall_mdl = 32'd0;
  endtask

  initial begin
    int nxt;

    // 1. Reset held five cycles, then the first cycle after release.
    do_reset(5);
    clr();
    cycle();
    chk("rst_tready", snap_tready, 1'b1);
    chk("rst_mvalid", snap_mvalid, 1'b0);
    chk("rst_mdata", snap_mdata, 64'd0);
    chk("rst_credit", snap_credit, 4);

    // 2. Single beat, visible exactly in cycle 3 for one cycle.
    clr();
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 64'hA5;
    cycle();
    s_axis_tvalid = 1'b0;
    repeat (6) cycle();
    chk("single_cnt", out_cyc.size(), 1);
    if (out_cyc.size() == 1) begin
      chk("single_lat", out_cyc[0], 3);
      chk("single_dat", out_dat[0], 64'hA5);
    end
    chk("single_vld_cycles", vld_cnt, 1);

    // 3. Sustained stream of 32 beats at full rate.
    clr();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'(i);
      cycle();
    end
    s_axis_tvalid = 1'b0;
    repeat (6) cycle();
    chk("stream_acc", acc_cyc.size(), 32);
    chk("stream_out", out_cyc.size(), 32);
    if (out_cyc.size() == 32) begin
      chk("stream_first", out_cyc[0], 3);
      chk("stream_last", out_cyc[31], 34);
      for (int k = 0; k < 32; k++) chk("stream_order", out_dat[k], 64'(k));
    end
    for (int k = 0; k < 32; k++) chk("stream_ready", rdy_log[k], 1'b1);

    // 4. Back-pressure: blocked through cycle 8, released at cycle 9, 10 beats.
`ifdef AXIS_PIPE_CTRL_STATS_EN
    begin
      logic [31:0] b0;
      logic [31:0] s0;
      b0 = beats_mdl;
      s0 = stall_mdl;
`endif
    clr();
    nxt = 0;
    for (int c = 0; c < 16; c++) begin
      m_axis_tready = (c >= 9);
      s_axis_tvalid = (nxt < 10);
      s_axis_tdata  = 64'(100 + nxt);
      cycle();
      if (snap_acc) nxt++;
    end
    s_axis_tvalid = 1'b0;
    repeat (8) cycle();
    chk("bp_acc", acc_cyc.size(), 10);
    if (acc_cyc.size() >= 5) begin
      chk("bp_acc3", acc_cyc[3], 3);
      chk("bp_acc4", acc_cyc[4], 10);
    end
    for (int k = 4; k < 10; k++) chk("bp_blocked", rdy_log[k], 1'b0);
    chk("bp_ready_back", rdy_log[10], 1'b1);
    chk("bp_out", out_cyc.size(), 10);
    if (out_cyc.size() == 10) begin
      chk("bp_first_out", out_cyc[0], 9);
      for (int k = 0; k < 10; k++) chk("bp_order", out_dat[k], 64'(100 + k));
    end
`ifdef AXIS_PIPE_CTRL_STATS_EN
      chk("stat_beats_delta", stat_beats - b0, 32'd10);
      chk("stat_stall_delta", stat_stall - s0, 32'd6);
    end
`endif

    // 5. Reset while beats are in flight and buffered.
    clr();
    m_axis_tready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'(200 + c);
      cycle();
    end
    s_axis_tvalid = 1'b0;
    cycle();
    do_reset(2);
    clr();
    m_axis_tready = 1'b1;
    repeat (6) cycle();
    chk("mrst_no_valid", vld_cnt, 0);
    chk("mrst_credit", snap_credit, 4);
    clr();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 64'h300;
    cycle();
    s_axis_tvalid = 1'b0;
    repeat (5) cycle();
    chk("mrst_out", out_cyc.size(), 1);
    if (out_cyc.size() == 1) begin
      chk("mrst_lat", out_cyc[0], 3);
      chk("mrst_dat", out_dat[0], 64'h300);
    end

`ifdef AXIS_PIPE_CTRL_STATS_EN
    // 6. Saturation of the beat counter from a preload.
    dut.stat_beats_r = 32'hFFFF_FFFE;
    beats_mdl        = 32'hFFFF_FFFE;
    clr();
    m_axis_tready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'(400 + c);
      cycle();
    end
    s_axis_tvalid = 1'b0;
    repeat (6) cycle();
    chk("stat_sat", stat_beats, 32'hFFFF_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_axis_reg_pipe_credit_ctrl
